// File: rtl/fetch_pipe_ctrl_pkg.sv
// Shared definitions for the fetch stage: HLT opcode, NOP encoding and the
// fetch/halt state encoding.
package fetch_pipe_ctrl_pkg;

  localparam int unsigned OPC_W   = 4;
  localparam int unsigned NOP_W   = 16;
  localparam int unsigned STATE_W = 2;

  localparam logic [OPC_W-1:0] OPC_HLT   = 4'hF;
  localparam logic [NOP_W-1:0] NOP_INSTR = 16'h0000;

  typedef enum logic [STATE_W-1:0] {
    RUN       = 2'd0,
    HALT_WAIT = 2'd1,
    HALTED    = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_pipe_ctrl_if_id_reg.sv
// IF/ID pipeline register with load enable, flush-to-NOP and a valid bit.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   i_load       load i_instr / i_pc_plus2 and mark valid
//   i_flush      replace contents with a NOP bubble (wins over i_load)
//   i_instr      fetched instruction
//   i_pc_plus2   PC+2 of the fetched instruction
//   o_instr, o_pc_plus2, o_valid   registered IF/ID contents
module fetch_pipe_ctrl_if_id_reg
  import fetch_pipe_ctrl_pkg::*;
#(
  parameter int unsigned PC_W    = 16,
  parameter int unsigned INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load,
  input  logic               i_flush,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [PC_W-1:0]    i_pc_plus2,
  output logic [INSTR_W-1:0] o_instr,
  output logic [PC_W-1:0]    o_pc_plus2,
  output logic               o_valid
);

  logic [INSTR_W-1:0] r_instr;
  logic [PC_W-1:0]    r_pc_plus2;
  logic               r_valid;

  // Flush only kills the instruction; pc_plus2 of a bubble is don't-care.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr    <= INSTR_W'(NOP_INSTR);
      r_pc_plus2 <= '0;
      r_valid    <= 1'b0;
    end else if (i_flush) begin
      r_instr    <= INSTR_W'(NOP_INSTR);
      r_valid    <= 1'b0;
    end else if (i_load) begin
      r_instr    <= i_instr;
      r_pc_plus2 <= i_pc_plus2;
      r_valid    <= 1'b1;
    end
  end

  assign o_instr    = r_instr;
  assign o_pc_plus2 = r_pc_plus2;
  assign o_valid    = r_valid;

endmodule

// File: rtl/fetch_pipe_ctrl.sv
// Fetch-stage controller: owns the PC and the IF/ID register, obeys the
// hazard unit's pc_write / if_id_write, applies branch redirects with a
// wrong-path flush, and halts after draining once a valid HLT reaches IF/ID.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   pc_write, if_id_write       hazard-unit enables
//   stall                       hazard-unit bubble request (counted only
//                               when IF_STALL_CNT_EN is defined)
//   branch_taken, branch_target redirect request from ID
//   imem_data                   instruction-memory read data for imem_addr
//   imem_addr                   current PC (straight from the PC register)
//   if_id_instr, if_id_pc_plus2, if_id_valid   IF/ID contents to ID
//   halted                      sticky halt flag
//   stall_cycles                saturating stall count (IF_STALL_CNT_EN only)
// Build option: IF_STALL_CNT_EN adds the stall_cycles counter and port.
module fetch_pipe_ctrl
  import fetch_pipe_ctrl_pkg::*;
#(
  parameter int unsigned      PC_W         = 16,
  parameter int unsigned      INSTR_W      = 16,
  parameter logic [PC_W-1:0]  RESET_PC     = '0,
  parameter int unsigned      DRAIN_CYCLES = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pc_write,
  input  logic               if_id_write,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [PC_W-1:0]    imem_addr,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [PC_W-1:0]    if_id_pc_plus2,
  output logic               if_id_valid,
  output logic               halted
`ifdef IF_STALL_CNT_EN
  ,
  output logic [15:0]        stall_cycles
`endif
);

  localparam int unsigned CNT_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

  fetch_state_e     r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_halted, w_halted_nxt;
  logic [PC_W-1:0]  r_pc, w_pc_nxt, w_pc_plus2;
  logic             w_if_id_load, w_if_id_flush, w_is_hlt;
  logic [INSTR_W-1:0] w_if_id_instr;
  logic             w_if_id_valid;

  assign w_pc_plus2 = r_pc + PC_W'(2);
  // A flushed bubble never halts, even if its bits look like HLT.
  assign w_is_hlt   = w_if_id_valid && (w_if_id_instr[INSTR_W-1 -: OPC_W] == OPC_HLT);

  // State, drain counter, halt flag and PC registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= RUN;
      r_cnt    <= '0;
      r_halted <= 1'b0;
      r_pc     <= RESET_PC;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_halted <= w_halted_nxt;
      r_pc     <= w_pc_nxt;
    end
  end

  // Next-state, next-PC and IF/ID control.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_halted_nxt  = r_halted;
    w_pc_nxt      = r_pc;
    w_if_id_load  = 1'b0;
    w_if_id_flush = 1'b0;
    case (r_state)
      RUN: begin
        if (w_is_hlt) begin
          // The detecting cycle itself freezes PC and IF/ID.
          w_state_nxt = HALT_WAIT;
          w_cnt_nxt   = CNT_W'(DRAIN_CYCLES);
        end else if (!pc_write || !if_id_write) begin
          // Hazard hold; a concurrent branch is re-presented by ID later.
          if (pc_write) w_pc_nxt = w_pc_plus2;
          w_if_id_load = if_id_write;
        end else if (branch_taken) begin
          w_pc_nxt      = branch_target;
          w_if_id_flush = 1'b1;
        end else begin
          w_pc_nxt     = w_pc_plus2;
          w_if_id_load = 1'b1;
        end
      end
      HALT_WAIT: begin
        // Counter value 0 only occurs when DRAIN_CYCLES is 0.
        if (r_cnt <= CNT_W'(1)) begin
          w_state_nxt  = HALTED;
          w_halted_nxt = 1'b1;
          w_cnt_nxt    = '0;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      HALTED: begin
        w_halted_nxt = 1'b1;
      end
      default: begin
        w_state_nxt = RUN;
      end
    endcase
  end

  fetch_pipe_ctrl_if_id_reg #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_if_id_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_if_id_load),
    .i_flush    (w_if_id_flush),
    .i_instr    (imem_data),
    .i_pc_plus2 (w_pc_plus2),
    .o_instr    (w_if_id_instr),
    .o_pc_plus2 (if_id_pc_plus2),
    .o_valid    (w_if_id_valid)
  );

  assign imem_addr   = r_pc;
  assign if_id_instr = w_if_id_instr;
  assign if_id_valid = w_if_id_valid;
  assign halted      = r_halted;

`ifdef IF_STALL_CNT_EN
  logic [15:0] r_stall_cycles;

  // Saturating count of stalled RUN cycles; frozen once halting starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= '0;
    end else if ((r_state == RUN) && stall && (r_stall_cycles != 16'hFFFF)) begin
      r_stall_cycles <= r_stall_cycles + 16'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
`else
  logic w_unused_stall;
  assign w_unused_stall = stall;
`endif

endmodule
